wptr_full_ctrl: RTL and testbench
=================================

# wptr_full_ctrl

Write-domain pointer and full-flag controller for the async FIFO. It consumes the two-flop-synchronised read pointer (`wq2_rptr`) in the `wclk` domain. It maintains the binary and Gray write pointers and drives the RAM write address/enable. It produces the full, almost-full, free-space and sticky overflow status seen by the producer.

## Interface

Parameters:
- `ADDR_WIDTH`, default 7: RAM address width. Depth is `DEPTH = 2**ADDR_WIDTH`. Pointers are `ADDR_WIDTH+1` bits, matching the synchroniser `PTR_WIDTH = 8`.
- `AFULL_THRESH`, default 4: `walmost_full` asserts when free entries ≤ this value. Legal range 1..DEPTH-1; elaboration fails otherwise.

Ports:
- `wclk`: input, 1 bit. Write clock.
- `wrst_n`: input, 1 bit. Asynchronous, active-low reset.
- `winc`: input, 1 bit. Producer write request.
- `wq2_rptr`: input, ADDR_WIDTH+1 bits. Gray read pointer, already synchronised into `wclk`.
- `wovf_clr`: input, 1 bit. Clears `woverflow`.
- `wen`: output, 1 bit. RAM write enable, combinational: `winc & ~wfull`.
- `waddr`: output, ADDR_WIDTH bits. RAM write address, equal to `wbin[ADDR_WIDTH-1:0]`.
- `wptr`: output, ADDR_WIDTH+1 bits. Registered Gray write pointer, sent to the read-side synchroniser.
- `wfull`: output, 1 bit. Registered full flag.
- `walmost_full`: output, 1 bit. Registered almost-full flag.
- `wfree`: output, ADDR_WIDTH+1 bits. Registered free-entry count, 0..DEPTH.
- `woverflow`: output, 1 bit. Sticky flag: a write was attempted while full.

## Operation

- Write acceptance:
  - `accept = winc & ~wfull`.
  - `wbin_next = wbin + accept`, modulo 2^(ADDR_WIDTH+1).
  - `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- Registers updated every `wclk` edge: `wbin <= wbin_next`, `wptr <= wgray_next`.
- Full detection:
  - `wfull <= (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]})`.
  - Requires ADDR_WIDTH ≥ 2; elaboration fails for smaller values.
- Free-space count:
  - `rbin_s = gray2bin(wq2_rptr)`.
  - `used = wbin_next - rbin_s`, modulo 2^(ADDR_WIDTH+1), so wrap is handled by modular subtraction.
  - `wfree <= DEPTH - used`.
  - `walmost_full <= (DEPTH - used) <= AFULL_THRESH`.
- Overflow flag:
  - `winc & wfull` sets `woverflow`.
  - `wovf_clr` clears it.
  - If set and clear occur in the same cycle, set wins.
  - A rejected write does not change `wbin`, `wptr` or `wfree`.
- Pointer wrap: the MSB toggles every DEPTH writes. Gray encoding guarantees exactly one bit changes per accepted write, including at the 2^(ADDR_WIDTH+1)-1 → 0 wrap.
- `wq2_rptr` is treated as stale but monotonic. Full/free status is therefore pessimistic: it may report fewer free entries than actually exist, never more.

## Timing

- Reset (asynchronous, takes effect immediately):
  - `wbin`, `wptr`, `waddr` = 0.
  - `wfull`, `walmost_full`, `woverflow` = 0.
  - `wfree` = DEPTH.
  - `wen` follows `winc`.
- Reset mid-operation: all state returns to reset values with no further writes. The read side must be reset together with the write side; reset coordination is outside this block.
- A write accepted at edge N updates `waddr`, `wptr` and `wfree` at edge N (one register stage). If that write filled the FIFO, `wfull` is 1 after edge N, so a `winc` in the next cycle is rejected.
- A change of `wq2_rptr` is reflected in `wfull`, `wfree` and `walmost_full` at the next `wclk` edge. From a read-side pointer change, total latency is 3 `wclk` edges (2 synchroniser edges + 1 here).
- Simultaneous write and read-pointer advance in the same cycle: both are applied; `wfree` is unchanged if the read pointer advanced by 1.
- `wen` is valid in the same cycle as `winc`; the RAM samples `waddr` and data at the same edge.

## Structure

- `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions, parameterised by width and shared with the read-side `rptr_empty`.
  - Localparam guidance for `PTR_WIDTH = ADDR_WIDTH + 1`.
- No sub-module. Implement as a single `always_ff` block plus combinational next-state logic, with `gray2bin` called from the package.

## Test plan

Bench configuration: ADDR_WIDTH=3 (DEPTH=8), AFULL_THRESH=2.

- Reset, then no stimulus → `wfree`=8, `wfull`=0, `walmost_full`=0, `wptr`=0, `woverflow`=0.
- 8 back-to-back writes with `wq2_rptr`=0 → `waddr` steps 0..7, `walmost_full` rises after the 6th write, `wfull` rises after the 8th, `wfree`=0, `wptr`=4'b1100.
- While full, `winc`=1 for 2 cycles:
  - `wen`=0 and `wptr` holds.
  - `woverflow`=1 and stays 1.
  - `wovf_clr` together with `winc` keeps it 1.
  - `wovf_clr` alone clears it.
- From full, drive `wq2_rptr`=Gray(1)=4'b0001 → `wfull` falls at the next edge, `wfree`=1, and one write is accepted.
- 20 writes with `wq2_rptr` tracking `wptr` delayed by 3 cycles → the pointer wraps 15→0, exactly one `wptr` bit changes per write, and `wfull` never asserts.
- Assert `wrst_n`=0 mid-burst with 5 entries used → all outputs return to reset values asynchronously, with no write after deassertion until `winc`.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width derivation and Gray/binary conversion.
// Functions operate on 32-bit zero-extended values so any pointer width up to 32 can use them.
package fifo_pkg;

  localparam int unsigned MaxPtrWidth = 32;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [MaxPtrWidth-1:0] bin2gray(input logic [MaxPtrWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits leave the low-order result unchanged.
  function automatic logic [MaxPtrWidth-1:0] gray2bin(input logic [MaxPtrWidth-1:0] g);
    logic [MaxPtrWidth-1:0] b;
    b[MaxPtrWidth-1] = g[MaxPtrWidth-1];
    for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/almost-full/free-space/overflow controller for the async FIFO.
// Status is computed against the synchronised (stale) read pointer, so it is pessimistic.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned AFULL_THRESH = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  wovf_clr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wfree,
  output logic                  woverflow
);

  localparam int unsigned PtrWidth = ptr_width(ADDR_WIDTH);
  localparam int unsigned Depth    = 1 << ADDR_WIDTH;
  localparam int unsigned Msb      = PtrWidth - 1;

  if (ADDR_WIDTH < 2) begin : g_bad_addr_width
    $error("wptr_full_ctrl: ADDR_WIDTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > Depth - 1) begin : g_bad_afull
    $error("wptr_full_ctrl: AFULL_THRESH must be in 1..DEPTH-1");
  end

  logic [PtrWidth-1:0] wbin_q, wbin_d;
  logic [PtrWidth-1:0] wgray_q, wgray_d;
  logic [PtrWidth-1:0] wfree_q, wfree_d;
  logic                wfull_q, wfull_d;
  logic                afull_q, afull_d;
  logic                ovf_q, ovf_d;

  logic                accept;
  logic [PtrWidth-1:0] full_cmp;
  logic [PtrWidth-1:0] rbin_s;
  logic [PtrWidth-1:0] used;
  logic [MaxPtrWidth-1:0] gray_wide, rbin_wide;

  always_comb begin
    accept    = winc & ~wfull_q;
    wbin_d    = wbin_q + PtrWidth'(accept);
    gray_wide = bin2gray(MaxPtrWidth'(wbin_d));
    wgray_d   = gray_wide[PtrWidth-1:0];

    // Full when write pointer leads the read pointer by exactly one lap.
    full_cmp  = {~wq2_rptr[Msb:Msb-1], wq2_rptr[Msb-2:0]};
    wfull_d   = (wgray_d == full_cmp);

    rbin_wide = gray2bin(MaxPtrWidth'(wq2_rptr));
    rbin_s    = rbin_wide[PtrWidth-1:0];
    used      = wbin_d - rbin_s;
    wfree_d   = PtrWidth'(Depth) - used;
    afull_d   = (wfree_d <= PtrWidth'(AFULL_THRESH));

    // Set has priority over clear.
    ovf_d     = (winc & wfull_q) | (ovf_q & ~wovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      wfree_q <= PtrWidth'(Depth);
      wfull_q <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfree_q <= wfree_d;
      wfull_q <= wfull_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wen          = winc & ~wfull_q;
  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr         = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = afull_q;
  assign wfree        = wfree_q;
  assign woverflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed self-checking bench for wptr_full_ctrl with DEPTH=8, AFULL_THRESH=2.
module tb_wptr_full_ctrl;

  localparam int unsigned AW = 3;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic          wovf_clr;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wfree;
  logic          woverflow;

  int checks = 0;
  int errors = 0;

  wptr_full_ctrl #(
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(2)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .winc        (winc),
    .wq2_rptr    (wq2_rptr),
    .wovf_clr    (wovf_clr),
    .wen         (wen),
    .waddr       (waddr),
    .wptr        (wptr),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wfree       (wfree),
    .woverflow   (woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; winc = 1'b1; wq2_rptr = '0; wovf_clr = 1'b0;
    #2;
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL reset_wen got %b want 1", wen); end
    winc = 1'b0;
    tick(); tick();
    wrst_n = 1'b1;
    tick();
    checks++; if (wfree !== 4'd8) begin errors++; $display("FAIL reset_wfree got %0d want 8", wfree); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b want 0", wfull); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", walmost_full); end
    checks++; if (wptr !== 4'd0) begin errors++; $display("FAIL reset_wptr got %h want 0", wptr); end
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", woverflow); end
    checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", waddr); end
  endtask

  task automatic test_fill();
    logic [3:0] eb;
    wq2_rptr = '0;
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1;
      #1;
      checks++; if (waddr !== 3'(i)) begin errors++; $display("FAIL fill_waddr[%0d] got %0d want %0d", i, waddr, i); end
      checks++; if (wen !== 1'b1) begin errors++; $display("FAIL fill_wen[%0d] got %b want 1", i, wen); end
      tick();
      eb = 4'(i + 1);
      checks++; if (wptr !== gray4(eb)) begin errors++; $display("FAIL fill_wptr[%0d] got %h want %h", i, wptr, gray4(eb)); end
      checks++; if (wfree !== 4'(7 - i)) begin errors++; $display("FAIL fill_wfree[%0d] got %0d want %0d", i, wfree, 7 - i); end
      checks++; if (walmost_full !== (i >= 5)) begin errors++; $display("FAIL fill_afull[%0d] got %b want %b", i, walmost_full, i >= 5); end
      checks++; if (wfull !== (i == 7)) begin errors++; $display("FAIL fill_wfull[%0d] got %b want %b", i, wfull, i == 7); end
    end
    winc = 1'b0;
    checks++; if (wptr !== 4'b1100) begin errors++; $display("FAIL fill_final_wptr got %b want 1100", wptr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      winc = 1'b1;
      #1;
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL ovf_wen[%0d] got %b want 0", i, wen); end
      tick();
      checks++; if (wptr !== 4'b1100) begin errors++; $display("FAIL ovf_wptr[%0d] got %b want 1100", i, wptr); end
      checks++; if (wfree !== 4'd0) begin errors++; $display("FAIL ovf_wfree[%0d] got %0d want 0", i, wfree); end
      checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_set[%0d] got %b want 1", i, woverflow); end
    end
    winc = 1'b1; wovf_clr = 1'b1;
    tick();
    checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", woverflow); end
    winc = 1'b0;
    tick();
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", woverflow); end
    wovf_clr = 1'b0;
    tick();
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL ovf_stays_clear got %b want 0", woverflow); end
  endtask

  task automatic test_read_release();
    winc = 1'b0; wq2_rptr = 4'b0001;
    tick();
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL rel_wfull got %b want 0", wfull); end
    checks++; if (wfree !== 4'd1) begin errors++; $display("FAIL rel_wfree got %0d want 1", wfree); end
    checks++; if (walmost_full !== 1'b1) begin errors++; $display("FAIL rel_afull got %b want 1", walmost_full); end
    winc = 1'b1;
    #1;
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL rel_wen got %b want 1", wen); end
    checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL rel_waddr got %0d want 0", waddr); end
    tick();
    winc = 1'b0;
    checks++; if (wptr !== 4'b1101) begin errors++; $display("FAIL rel_wptr got %b want 1101", wptr); end
    checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL rel_refull got %b want 1", wfull); end
    checks++; if (wfree !== 4'd0) begin errors++; $display("FAIL rel_wfree0 got %0d want 0", wfree); end
  endtask

  task automatic test_wrap();
    logic [3:0] eb, rb, prev, diff;
    int         ones;
    bit         wrapped;
    wrapped = 1'b0;
    // Read side catches up to the write pointer (bin 9).
    winc = 1'b0; wq2_rptr = gray4(4'd9);
    tick();
    checks++; if (wfree !== 4'd8) begin errors++; $display("FAIL wrap_empty_wfree got %0d want 8", wfree); end
    prev = wptr;
    for (int k = 0; k < 20; k++) begin
      rb = 4'(9 + ((k >= 3) ? k - 3 : 0));
      eb = 4'(9 + k + 1);
      wq2_rptr = gray4(rb);
      winc = 1'b1;
      tick();
      diff = wptr ^ prev;
      ones = 0;
      for (int b = 0; b < 4; b++) ones += int'(diff[b]);
      checks++; if (wptr !== gray4(eb)) begin errors++; $display("FAIL wrap_wptr[%0d] got %h want %h", k, wptr, gray4(eb)); end
      checks++; if (ones != 1) begin errors++; $display("FAIL wrap_onebit[%0d] got %0d bits want 1", k, ones); end
      checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL wrap_wfull[%0d] got %b want 0", k, wfull); end
      checks++; if (wfree !== 4'(8 - (k + 1 - ((k >= 3) ? k - 3 : 0)))) begin
        errors++; $display("FAIL wrap_wfree[%0d] got %0d want %0d", k, wfree, 8 - (k + 1 - ((k >= 3) ? k - 3 : 0)));
      end
      if (prev == gray4(4'd15) && wptr == 4'd0) wrapped = 1'b1;
      prev = wptr;
    end
    winc = 1'b0;
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_seen got %b want 1", wrapped); end
  endtask

  task automatic test_reset_mid();
    // Write pointer is at bin 13; make the FIFO empty, then fill 5 entries.
    winc = 1'b0; wq2_rptr = gray4(4'd13);
    tick();
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1;
      tick();
    end
    checks++; if (wfree !== 4'd3) begin errors++; $display("FAIL mid_wfree_pre got %0d want 3", wfree); end
    #2;
    wrst_n = 1'b0;
    #1;
    checks++; if (wptr !== 4'd0) begin errors++; $display("FAIL mid_wptr got %h want 0", wptr); end
    checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL mid_waddr got %0d want 0", waddr); end
    checks++; if (wfree !== 4'd8) begin errors++; $display("FAIL mid_wfree got %0d want 8", wfree); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL mid_wfull got %b want 0", wfull); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL mid_afull got %b want 0", walmost_full); end
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", woverflow); end
    winc = 1'b0; wq2_rptr = '0;
    tick();
    wrst_n = 1'b1;
    tick(); tick();
    checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL mid_idle_waddr got %0d want 0", waddr); end
    checks++; if (wfree !== 4'd8) begin errors++; $display("FAIL mid_idle_wfree got %0d want 8", wfree); end
    winc = 1'b1;
    tick();
    winc = 1'b0;
    checks++; if (waddr !== 3'd1) begin errors++; $display("FAIL mid_resume_waddr got %0d want 1", waddr); end
    checks++; if (wptr !== 4'b0001) begin errors++; $display("FAIL mid_resume_wptr got %b want 0001", wptr); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
